// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings, exception codes,
// controller state enum and the stall-request priority merge.
package pipe_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit k freezes stage k (bit0 = PC); a request freezes its own stage and all earlier ones.
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_IF   = {{4{NO_STOP}}, {2{STOP}}};
    localparam logic [5:0] STALL_ID   = {{3{NO_STOP}}, {3{STOP}}};
    localparam logic [5:0] STALL_EX   = {{2{NO_STOP}}, {4{STOP}}};
    localparam logic [5:0] STALL_MEM  = {{1{NO_STOP}}, {5{STOP}}};

    localparam logic [31:0] EXC_NONE        = 32'h0000_0000;
    localparam logic [31:0] EXC_ERET_CODE   = 32'h0000_000e;
    localparam logic [31:0] EXC_VECTOR_ADDR = 32'h0000_0020;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } ctrl_state_e;

    function automatic logic [5:0] merge_stall(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall bookkeeping: saturating total stall-cycle counter, consecutive-stall run
// counter and a sticky timeout flag raised when a run reaches STALL_TIMEOUT cycles.
module pipe_ctrl_stall_watchdog #(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_active,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             timeout
);

    localparam int RUN_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        cnt_d     = cnt_q;
        run_d     = run_q;
        timeout_d = timeout_q;
        if (stall_active && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // run_q counts stall cycles already completed, so hitting RUN_MAX while
        // still stalling means this is the STALL_TIMEOUT-th consecutive cycle.
        if (clear || !stall_active) begin
            run_d = '0;
        end else begin
            if (run_q == RUN_MAX) begin
                timeout_d = 1'b1;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign cnt     = cnt_q;
    assign timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, turns MEM-stage exceptions into a
// flush + redirect, holds a post-flush recovery window and tracks stall statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_ADDR,
    parameter logic [31:0] EXC_ERET      = EXC_ERET_CODE,
    parameter int          RECOVER_CYC   = 2,
    parameter int          STALL_TIMEOUT = 1024,
    parameter int          STALL_CNT_W   = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stallreq_if,
    input  logic        i_stallreq_id,
    input  logic        i_stallreq_ex,
    input  logic        i_stallreq_mem,
    input  logic [31:0] i_except_type,
    input  logic [31:0] i_cp0_epc,
    output logic [5:0]  o_stall,
    output logic        o_flush,
    output logic [31:0] o_new_pc,
    output logic [31:0] o_stall_cnt,
    output logic        o_stall_timeout,
    output ctrl_state_e o_state
);

    localparam int REC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [REC_W-1:0] REC_LOAD = (RECOVER_CYC > 0) ? REC_W'(RECOVER_CYC - 1) : '0;

    ctrl_state_e            state_q, state_d;
    logic [REC_W-1:0]       rec_cnt_q, rec_cnt_d;
    logic                   exc_hit;
    logic [STALL_CNT_W-1:0] wd_cnt;
    logic                   wd_timeout;

    // Exceptions are only honoured outside the recovery window.
    assign exc_hit = (state_q == IDLE) && (i_except_type != EXC_NONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            rec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rec_cnt_q <= rec_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        case (state_q)
            IDLE: begin
                if (exc_hit && (RECOVER_CYC > 0)) begin
                    state_d   = RECOVER;
                    rec_cnt_d = REC_LOAD;
                end
            end
            RECOVER: begin
                if (rec_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    rec_cnt_d = rec_cnt_q - REC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_stall  = merge_stall(i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem);
        o_flush  = 1'b0;
        o_new_pc = '0;
        if (exc_hit) begin
            o_stall  = STALL_NONE;
            o_flush  = 1'b1;
            o_new_pc = (i_except_type == EXC_ERET) ? i_cp0_epc : EXC_VECTOR;
        end
        // Hold every consumer quiet while reset is asserted, even if requests are live.
        if (!i_rst_n) begin
            o_stall  = STALL_NONE;
            o_flush  = 1'b0;
            o_new_pc = '0;
        end
    end

    pipe_ctrl_stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .CNT_W         (STALL_CNT_W)
    ) u_stall_watchdog (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .stall_active (|o_stall),
        .clear        (o_flush),
        .cnt          (wd_cnt),
        .timeout      (wd_timeout)
    );

    always_comb begin
        o_stall_cnt                  = '0;
        o_stall_cnt[STALL_CNT_W-1:0] = wd_cnt;
    end

    assign o_stall_timeout = wd_timeout;
    assign o_state         = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver issues one cycle of stimulus at a time and
// pushes the reference model's expectation; a monitor pops and compares on the falling edge.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int REC_CYC = 2;
    localparam int TIMEOUT = 8;
    localparam int SAT_W   = 3;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        r_if = 1'b0, r_id = 1'b0, r_ex = 1'b0, r_mem = 1'b0;
    logic [31:0] exc_type = '0, epc = '0;

    logic [5:0]  o_stall,  s_stall;
    logic        o_flush,  s_flush;
    logic [31:0] o_new_pc, s_new_pc;
    logic [31:0] o_stall_cnt, s_stall_cnt;
    logic        o_stall_timeout, s_stall_timeout;
    ctrl_state_e o_state, s_state;

    always #5 clk = ~clk;

    pipe_ctrl #(.RECOVER_CYC(REC_CYC), .STALL_TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_stallreq_if(r_if), .i_stallreq_id(r_id), .i_stallreq_ex(r_ex), .i_stallreq_mem(r_mem),
        .i_except_type(exc_type), .i_cp0_epc(epc),
        .o_stall(o_stall), .o_flush(o_flush), .o_new_pc(o_new_pc),
        .o_stall_cnt(o_stall_cnt), .o_stall_timeout(o_stall_timeout), .o_state(o_state)
    );

    // Narrow-counter copy on the same inputs so saturation is reachable in a short run.
    pipe_ctrl #(.RECOVER_CYC(REC_CYC), .STALL_TIMEOUT(TIMEOUT), .STALL_CNT_W(SAT_W)) dut_sat (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_stallreq_if(r_if), .i_stallreq_id(r_id), .i_stallreq_ex(r_ex), .i_stallreq_mem(r_mem),
        .i_except_type(exc_type), .i_cp0_epc(epc),
        .o_stall(s_stall), .o_flush(s_flush), .o_new_pc(s_new_pc),
        .o_stall_cnt(s_stall_cnt), .o_stall_timeout(s_stall_timeout), .o_state(s_state)
    );

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic [31:0] cnt;
        logic [31:0] sat_cnt;
        logic        timeout;
        logic        recover;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: plain counts, not the RTL's encoding.
    int              rec_left = 0;
    longint unsigned stalls   = 0;
    int              run_len  = 0;
    bit              to_flag  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit f_if, input bit f_id, input bit f_ex,
                         input bit f_mem, input logic [31:0] exc, input logic [31:0] pc);
        exp_t e;
        @(posedge clk);
        #1;
        i_rst_n  = !rst;
        r_if     = f_if;
        r_id     = f_id;
        r_ex     = f_ex;
        r_mem    = f_mem;
        exc_type = exc;
        epc      = pc;
        e = '0;
        if (rst) begin
            rec_left = 0;
            stalls   = 0;
            run_len  = 0;
            to_flag  = 1'b0;
        end else begin
            e.cnt     = (stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(stalls);
            e.sat_cnt = (stalls > 7) ? 32'd7 : 32'(stalls);
            e.timeout = to_flag;
            e.recover = (rec_left > 0);
            if (exc != 0 && rec_left == 0) begin
                e.stall  = 6'b000000;
                e.flush  = 1'b1;
                e.new_pc = (exc == 32'h0000_000e) ? pc : 32'h0000_0020;
                rec_left = REC_CYC;
            end else begin
                if (f_mem)     e.stall = 6'b011111;
                else if (f_ex) e.stall = 6'b001111;
                else if (f_id) e.stall = 6'b000111;
                else if (f_if) e.stall = 6'b000011;
                else           e.stall = 6'b000000;
                if (rec_left > 0) rec_left--;
            end
            if (e.stall != 0) begin
                stalls++;
                run_len++;
                if (run_len >= TIMEOUT) to_flag = 1'b1;
            end else begin
                run_len = 0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall",       {26'd0, o_stall},         {26'd0, e.stall});
            check("flush",       {31'd0, o_flush},         {31'd0, e.flush});
            check("new_pc",      o_new_pc,                 e.new_pc);
            check("stall_cnt",   o_stall_cnt,              e.cnt);
            check("sat_cnt",     s_stall_cnt,              e.sat_cnt);
            check("timeout",     {31'd0, o_stall_timeout}, {31'd0, e.timeout});
            check("state",       {31'd0, o_state == RECOVER}, {31'd0, e.recover});
        end
    end

    initial begin
        int k;
        logic [31:0] ex;

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 1, 32'h8, 0);
        idle(1);

        // Single EX stall for three cycles, count then visible.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0);
        idle(2);

        // Priority: MEM beats IF; ID alone; IF alone.
        drive(0, 1, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0);
        idle(1);

        // Exception, then exceptions inside the recovery window are ignored.
        drive(0, 0, 0, 0, 0, 32'h8, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h8, 32'h0);
        drive(0, 0, 1, 0, 0, 32'h4, 32'h0);
        drive(0, 0, 0, 0, 0, 32'hc, 32'h0);
        idle(3);

        // ERET with a concurrent ID stall.
        drive(0, 0, 1, 0, 0, 32'he, 32'h1000);
        idle(3);

        // Watchdog: MEM held long enough, then released.
        for (int i = 0; i < TIMEOUT + 1; i++) drive(0, 0, 0, 0, 1, 0, 0);
        idle(3);

        // Reset mid-recover and mid-stall, then an exception right after reset.
        drive(0, 0, 0, 0, 0, 32'h8, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 32'he, 32'h2468);
        idle(3);

        // Watchdog cleared by a flush partway through a run.
        for (int i = 0; i < TIMEOUT - 2; i++) drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 32'h10, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) drive(0, 0, 0, 1, 0, 0, 0);
        idle(3);

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            case (k)
                0:       ex = 32'h8;
                1:       ex = 32'he;
                2:       ex = $urandom | 32'h1;
                default: ex = 32'h0;
            endcase
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  ex, $urandom);
        end
        idle(2);

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
